// File: rtl/bit_replicator_seq.sv
// Sequential bit replicator: captures a request, then shifts the selected b bit
// in one copy per clock to build {0.., a, bb x n, cb}, and holds it until taken.
module bit_replicator_seq #(
   parameter  int B_W     = 2,
   parameter  int C_W     = 3,
   parameter  int MAX_REP = 4,
   localparam int Y_W     = MAX_REP + 2,
   localparam int R_W     = $clog2(MAX_REP + 1),
   localparam int BS_W    = (B_W > 1) ? $clog2(B_W) : 1,
   localparam int CS_W    = (C_W > 1) ? $clog2(C_W) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             a,
   input  logic [B_W-1:0]   b,
   input  logic [C_W-1:0]   c,
   input  logic [BS_W-1:0]  b_sel,
   input  logic [CS_W-1:0]  c_sel,
   input  logic [R_W:0]     rep,
   output logic [Y_W-1:0]   y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             clamped
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUILD = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [R_W-1:0]  count;
   logic            bb_bit;

   logic            accept;
   logic            handshake;
   logic            bb_in;
   logic            cb_in;
   logic            clamp_in;
   logic [R_W-1:0]  n_in;

   assign in_ready  = (state == IDLE);
   assign accept    = in_valid && in_ready;
   assign handshake = out_valid && out_ready;

   // Out-of-range selects read as 0 rather than wrapping or flagging.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      bb_in    = 1'b0;
      cb_in    = 1'b0;
      if (int'(b_sel) < B_W) bb_in = b[b_sel];
      if (int'(c_sel) < C_W) cb_in = c[c_sel];
      clamp_in = (rep > (R_W+1)'(MAX_REP));
      n_in     = clamp_in ? R_W'(MAX_REP) : rep[R_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (accept) next_state = (n_in == '0) ? DONE : BUILD;
         end
         BUILD: begin
            if (count == R_W'(1)) next_state = DONE;
         end
         DONE: begin
            if (handshake) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Shifting inserts bb at bit 1, so cb stays at bit 0 and a walks upward.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y         <= '0;
         count     <= '0;
         bb_bit    <= 1'b0;
         clamped   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  y         <= {{(Y_W-2){1'b0}}, a, cb_in};
                  count     <= n_in;
                  bb_bit    <= bb_in;
                  clamped   <= clamp_in;
                  out_valid <= 1'b0;
               end
            end
            BUILD: begin
               y     <= {y[Y_W-2:1], bb_bit, y[0]};
               count <= count - R_W'(1);
            end
            DONE: begin
               // One registered settle cycle in DONE before the result is offered.
               if (!out_valid)     out_valid <= 1'b1;
               else if (out_ready) out_valid <= 1'b0;
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end

endmodule
